// File: rtl/spi_fram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_fram_responder                                           |
// | Description : SPI mode-0 responder emulating the FM25L16 WRITE/READ subset |
// |               over a small register memory, with write strobe and peek.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_fram_responder #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_si,
    output logic              spi_so,
    output logic              busy,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] peek_addr,
    output logic [DATA_W-1:0] peek_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_OP   = 3'd1;
    localparam logic [2:0] S_AH   = 3'd2;
    localparam logic [2:0] S_AL   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_RD   = 3'd5;
    localparam logic [2:0] S_IGN  = 3'd6;

    localparam logic [7:0] c_OP_WRITE = 8'h02;
    localparam logic [7:0] c_OP_READ  = 8'h03;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_si_sync;
    logic                   r_sclk_d;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_rx_shift;
    logic [6:0]        r_tx_shift;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_read;
    logic              r_rd_reload;
    logic              r_spi_so;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic       w_sclk_s;
    logic       w_cs_s;
    logic       w_si_s;
    logic       w_rise;
    logic       w_fall;
    logic       w_byte_done;
    logic [7:0] w_rx_byte;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_si_s      = r_si_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk_s & ~r_sclk_d;
    assign w_fall      = ~w_sclk_s & r_sclk_d;
    assign w_rx_byte   = {r_rx_shift, w_si_s};
    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7) && (r_state != S_IDLE) && !w_cs_s;

    assign spi_so    = r_spi_so;
    assign busy      = ~w_cs_s;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign peek_data = r_mem[peek_addr];

    // Bring the asynchronous SPI pins into the clk domain; chip select resets deselected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_si_sync   <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_si_sync   <= {r_si_sync[SYNC_STAGES-2:0], spi_si};
            r_sclk_d    <= w_sclk_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: a deselect always wins and returns to idle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_s) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_OP;
                S_OP: begin
                    if (w_byte_done) begin
                        if (w_rx_byte == c_OP_WRITE || w_rx_byte == c_OP_READ) begin
                            w_state_nxt = S_AH;
                        end else begin
                            w_state_nxt = S_IGN;
                        end
                    end
                end
                S_AH: if (w_byte_done) w_state_nxt = S_AL;
                S_AL: if (w_byte_done) w_state_nxt = r_is_read ? S_RD : S_WR;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Shift registers, address pointer, memory writes and read-data serialisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 7'd0;
            r_tx_shift  <= 7'd0;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_rd_reload <= 1'b0;
            r_spi_so    <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_cs_s || r_state == S_IDLE) begin
                // Any partial byte is dropped here.
                r_bit_cnt   <= 3'd0;
                r_spi_so    <= 1'b0;
                r_rd_reload <= 1'b0;
            end else begin
                if (w_rise) begin
                    r_rx_shift <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                case (r_state)
                    S_OP: begin
                        if (w_byte_done) r_is_read <= (w_rx_byte == c_OP_READ);
                    end
                    S_AL: begin
                        if (w_byte_done) begin
                            r_addr <= w_rx_byte[ADDR_W-1:0];
                            if (r_is_read) begin
                                r_spi_so    <= r_mem[w_rx_byte[ADDR_W-1:0]][7];
                                r_tx_shift  <= r_mem[w_rx_byte[ADDR_W-1:0]][6:0];
                                // The next falling edge reloads the same byte rather than shifting.
                                r_rd_reload <= 1'b1;
                            end
                        end
                    end
                    S_WR: begin
                        if (w_byte_done) begin
                            r_mem[r_addr] <= w_rx_byte;
                            r_wr_strobe   <= 1'b1;
                            r_wr_addr     <= r_addr;
                            r_wr_data     <= w_rx_byte;
                            r_addr        <= r_addr + ADDR_W'(1);
                        end
                    end
                    S_RD: begin
                        if (w_byte_done) begin
                            r_addr      <= r_addr + ADDR_W'(1);
                            r_rd_reload <= 1'b1;
                        end else if (w_fall) begin
                            if (r_rd_reload) begin
                                r_spi_so    <= r_mem[r_addr][7];
                                r_tx_shift  <= r_mem[r_addr][6:0];
                                r_rd_reload <= 1'b0;
                            end else begin
                                r_spi_so   <= r_tx_shift[6];
                                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                            end
                        end
                    end
                    default: r_spi_so <= 1'b0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_fram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_fram_responder                                        |
// | Description : Self-checking bench acting as SPI master for the FRAM        |
// |               responder, with a behavioural memory model.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_fram_responder;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int HALF   = 80;

    logic              clk;
    logic              rst_n;
    logic              spi_clk;
    logic              spi_cs;
    logic              spi_si;
    logic              spi_so;
    logic              busy;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] peek_addr;
    logic [7:0]        peek_data;

    spi_fram_responder #(.ADDR_W(ADDR_W), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .spi_si    (spi_si),
        .spi_so    (spi_so),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .peek_addr (peek_addr),
        .peek_data (peek_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem_m [DEPTH];
    logic [13:0] sq [$];
    logic [7:0]  tx_buf [8];
    logic [7:0]  rx_buf [8];

    typedef struct {
        logic [7:0]  op;
        logic [15:0] addr;
        int          n;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  e0;
        logic [7:0]  e1;
        int          e_strobes;
    } vec_t;

    vec_t vecs [5];

    // Record every write strobe seen, one entry per high clk cycle.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) sq.push_back({wr_addr, wr_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_si = b;
        #HALF;
        r = spi_so;
        spi_clk = 1'b1;
        #HALF;
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
        logic bit_r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(t[i], bit_r);
            r[i] = bit_r;
        end
    endtask

    task automatic cs_end();
        #HALF;
        spi_cs = 1'b1;
        spi_si = 1'b0;
        #(HALF + 20);
        check("so_idle", {31'd0, spi_so}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    // Full transaction: opcode, 16-bit address, n data bytes from tx_buf.
    task automatic txn(input logic [7:0] op, input logic [15:0] a, input int n);
        logic [7:0] dummy;
        spi_cs = 1'b0;
        #HALF;
        check("busy_active", {31'd0, busy}, 32'd1);
        spi_byte(op, dummy);
        spi_byte(a[15:8], dummy);
        spi_byte(a[7:0], dummy);
        for (int i = 0; i < n; i++) spi_byte(tx_buf[i], rx_buf[i]);
        cs_end();
    endtask

    task automatic model_write(input logic [15:0] a, input int n);
        logic [ADDR_W-1:0] idx;
        check("strobe_count", sq.size(), n);
        for (int i = 0; i < n; i++) begin
            idx = ADDR_W'((a + i) % DEPTH);
            mem_m[idx] = tx_buf[i];
            if (sq.size() > 0) check("strobe_entry", {18'd0, sq.pop_front()}, {18'd0, idx, tx_buf[i]});
        end
        sq.delete();
    endtask

    task automatic model_read(input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) check("read_byte", rx_buf[i], mem_m[(a + i) % DEPTH]);
        check("read_no_strobe", sq.size(), 0);
        sq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0]  op;
        logic [15:0] a;
        int          n;
        logic        b;

        vecs[0] = '{op: 8'h02, addr: 16'h0005, n: 1, d0: 8'h03, d1: 8'h00, e0: 8'h00, e1: 8'h00, e_strobes: 1};
        vecs[1] = '{op: 8'h03, addr: 16'h0005, n: 1, d0: 8'h00, d1: 8'h00, e0: 8'h03, e1: 8'h00, e_strobes: 0};
        vecs[2] = '{op: 8'h02, addr: 16'h003F, n: 2, d0: 8'hAA, d1: 8'h55, e0: 8'h00, e1: 8'h00, e_strobes: 2};
        vecs[3] = '{op: 8'h03, addr: 16'h003F, n: 2, d0: 8'h00, d1: 8'h00, e0: 8'hAA, e1: 8'h55, e_strobes: 0};
        vecs[4] = '{op: 8'h03, addr: 16'h7C00, n: 1, d0: 8'h00, d1: 8'h00, e0: 8'h55, e1: 8'h00, e_strobes: 0};

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        rst_n = 1'b0; spi_clk = 1'b0; spi_cs = 1'b1; spi_si = 1'b0; peek_addr = '0;
        #53;
        check("rst_so", {31'd0, spi_so}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_peek", {24'd0, peek_data}, 32'd0);
        rst_n = 1'b1;
        #100;

        // Directed table: single write, read-back, burst wrap, wrapped burst read.
        for (int v = 0; v < 5; v++) begin
            tx_buf[0] = vecs[v].d0;
            tx_buf[1] = vecs[v].d1;
            txn(vecs[v].op, vecs[v].addr, vecs[v].n);
            check("vec_strobes", sq.size(), vecs[v].e_strobes);
            if (vecs[v].op == 8'h02) begin
                for (int i = 0; i < vecs[v].n; i++) begin
                    if (sq.size() > 0)
                        check("vec_strobe_entry", {18'd0, sq.pop_front()},
                              {18'd0, 6'((vecs[v].addr + i) % DEPTH), tx_buf[i]});
                    mem_m[(vecs[v].addr + i) % DEPTH] = tx_buf[i];
                end
            end else begin
                check("vec_rd0", rx_buf[0], vecs[v].e0);
                if (vecs[v].n > 1) check("vec_rd1", rx_buf[1], vecs[v].e1);
            end
            sq.delete();
        end
        peek_addr = 6'd5;  #1; check("peek5", peek_data, 8'h03);
        peek_addr = 6'd63; #1; check("peek63", peek_data, 8'hAA);
        peek_addr = 6'd0;  #1; check("peek0", peek_data, 8'h55);

        // Randomized transactions against the model.
        for (int t = 0; t < 16; t++) begin
            a = 16'($urandom);
            n = int'($urandom_range(1, 3));
            op = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h03;
            for (int i = 0; i < n; i++) tx_buf[i] = (op == 8'h02) ? 8'($urandom) : 8'h00;
            txn(op, a, n);
            if (op == 8'h02) model_write(a, n);
            else model_read(a, n);
            peek_addr = 6'($urandom);
            #1;
            check("rand_peek", peek_data, mem_m[peek_addr]);
        end

        // Abort mid-byte: no write, next transaction decodes normally.
        mem_m[7] = 8'h3C;
        tx_buf[0] = 8'h3C;
        txn(8'h02, 16'h0007, 1);
        sq.delete();
        spi_cs = 1'b0;
        #HALF;
        spi_byte(8'h02, rx_buf[7]);
        spi_byte(8'h00, rx_buf[7]);
        spi_byte(8'h07, rx_buf[7]);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        cs_end();
        check("abort_no_strobe", sq.size(), 0);
        peek_addr = 6'd7; #1;
        check("abort_mem7", peek_data, mem_m[7]);
        txn(8'h03, 16'h0007, 1);
        model_read(16'h0007, 1);

        // Unknown opcode followed by 16 clocks of ones.
        spi_cs = 1'b0;
        #HALF;
        spi_byte(8'h06, rx_buf[7]);
        for (int i = 0; i < 16; i++) begin
            spi_bit(1'b1, b);
            check("ign_so", {31'd0, b}, 32'd0);
        end
        cs_end();
        check("ign_no_strobe", sq.size(), 0);
        for (int i = 0; i < DEPTH; i++) begin
            peek_addr = 6'(i); #1;
            check("ign_mem", peek_data, mem_m[i]);
        end

        // Reset during the second byte of a burst read.
        spi_cs = 1'b0;
        #HALF;
        spi_byte(8'h03, rx_buf[7]);
        spi_byte(8'h00, rx_buf[7]);
        spi_byte(8'h05, rx_buf[7]);
        spi_byte(8'h00, rx_buf[0]);
        check("pre_rst_read", rx_buf[0], mem_m[5]);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        #23;
        rst_n = 1'b0;
        #20;
        check("midrst_so", {31'd0, spi_so}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("midrst_wr", {18'd0, wr_addr, wr_data}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            peek_addr = 6'(i); #1;
            check("midrst_peek", peek_data, 8'h00);
            mem_m[i] = 8'h00;
        end
        spi_cs = 1'b1;
        #37;
        rst_n = 1'b1;
        #200;
        sq.delete();
        tx_buf[0] = 8'h5A;
        txn(8'h02, 16'h0009, 1);
        model_write(16'h0009, 1);
        txn(8'h03, 16'h0008, 2);
        model_read(16'h0008, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_fram_responder.md
Name: spi_fram_responder

Overview:
- SPI mode-0 responder that emulates the FM25L16 FRAM command subset: WRITE (0x02) and READ (0x03), each followed by a 16-bit address.
- Backed by a small internal register memory.
- Sits on the bench or board side of the SPI bus, opposite the SPI memory master. It lets the board-state store run and be verified without a physical FRAM.
- Provides a write-event strobe and a combinational peek port for the host logic.

Parameters:
- ADDR_W, 6: memory index width; DEPTH = 2**ADDR_W entries.
- DATA_W, 8: entry width; fixed at 8 to match the SPI byte.
- SYNC_STAGES, 2: synchronizer depth on spi_clk, spi_cs, spi_si.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- spi_clk  in  1  SPI clock from master; idles low.
- spi_cs  in  1  chip select, active low.
- spi_si  in  1  serial data from master (master's SO).
- spi_so  out  1  serial data to master (master's SI).
- busy  out  1  high while synchronized spi_cs is low.
- wr_strobe  out  1  one-clk pulse per completed write byte.
- wr_addr  out  ADDR_W  index written on wr_strobe.
- wr_data  out  8  byte written on wr_strobe.
- peek_addr  in  ADDR_W  host read index.
- peek_data  out  8  mem[peek_addr], combinational.

Behaviour:
- Clocking and reset:
  - One clock; all state is on clk.
  - rst_n is asynchronous and active low.
  - Reset values: spi_so=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, state=S_IDLE, all memory entries=0.
- Input conditioning:
  - spi_clk, spi_cs and spi_si each pass through a SYNC_STAGES flop chain.
  - Rising and falling edges are detected on the synchronized spi_clk with one extra register.
- Bus timing requirement:
  - spi_clk high and low phases must each be at least SYNC_STAGES+2 clk cycles.
  - Faster spi_clk is unsupported; behaviour is undefined.
- Sampling and output timing:
  - spi_si is sampled on the detected spi_clk rising edge.
  - spi_so changes only on the detected falling edge or when a read byte is loaded.
  - Bits are MSB first.
- State machine:
  - S_IDLE: wait for synchronized spi_cs low; then clear bit_cnt and go to S_OP.
  - S_OP: shift 8 bits. On the 8th rising edge:
    - opcode 0x02 -> S_AH with is_read=0.
    - opcode 0x03 -> S_AH with is_read=1.
    - any other opcode -> S_IGN.
  - S_AH: shift 8 bits (address high byte) -> S_AL. These bits are received and discarded.
  - S_AL: shift 8 bits. On the 8th rising edge:
    - addr <= received[ADDR_W-1:0].
    - if is_read, load tx_shift <= mem[that index], drive spi_so <= its bit 7, go to S_RD.
    - else go to S_WR.
  - S_WR: shift 8 bits. On the 8th rising edge, in the same cycle:
    - write mem[addr]; addr <= addr+1 (wraps modulo DEPTH);
    - wr_strobe=1 for exactly one clk, with wr_addr/wr_data holding the index and byte just written.
    - Stay in S_WR (burst).
  - S_RD:
    - On each falling edge except the one following the 8th rising edge: tx_shift <= tx_shift<<1 and spi_so <= the new bit 7.
    - On the 8th rising edge: addr <= addr+1 (wraps modulo DEPTH).
    - On the following falling edge: reload tx_shift from mem[addr] and drive its bit 7.
    - Stay in S_RD (burst).
  - S_IGN: spi_so=0; ignore all bits until spi_cs goes high.
- spi_so outside S_RD is 0 (no tristate).
- Deassertion and re-selection:
  - Synchronized spi_cs high in any state -> S_IDLE next cycle, spi_so=0, bit_cnt=0.
  - A partial byte is discarded and produces no memory write and no wr_strobe.
  - A new selection after deselect always starts at S_OP.
- bit_cnt is 3 bits and wraps 7->0 at each byte boundary.
- Peek collision: peek_data reflects the write in the clk cycle after the write. If peek_addr equals the write index in the write cycle, peek_data shows the old value.
- Reset mid-transaction: immediate return to reset values; memory is cleared.

Test Plan:
- Single write: CS low, send 0x02,0x00,0x05,0x03, CS high -> one wr_strobe with wr_addr=5, wr_data=0x03; peek_addr=5 gives 0x03; busy high only while CS low.
- Read-back: after the single write, send 0x03,0x00,0x05 then 8 dummy clocks -> master samples 0x03 (bits 0,0,0,0,0,0,1,1); spi_so=0 after CS high.
- Burst wrap: send 0x02,0x00,0x3F then data 0xAA,0x55 -> two strobes, (63,0xAA) then (0,0x55); a burst read from 0x3F returns 0xAA then 0x55.
- Abort: send 0x02,0x00,0x07 and 5 bits of data, then CS high -> no wr_strobe and mem[7] unchanged. The next transaction decodes normally from its opcode.
- Unknown opcode: send 0x06 then 16 clocks with spi_si=1 -> no strobe, no memory change, spi_so stays 0.
- Reset mid-read: assert rst_n low during S_RD byte 2 -> all outputs 0 and peek_data=0 for every address. A subsequent write/read pair works.
